pixie_dma_source: RTL

CPU-side DMA/interrupt source for the Pixie display path: the transmitting end of the bus protocol consumed by the Pixie front end. It sequences CDP1802-style machine cycles (8 qualified clocks each), answers Pixie DMA-out requests with S2 cycles that fetch display bytes from RAM via an internal R0 pointer, and answers the Pixie interrupt with an S3 cycle that reloads R0 with the display base. It also issues the disp_on/disp_off strobes. It sits between program RAM and the Pixie front end, in the CPU bus clock domain.

---
 rtl/pixie_dma_source.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/pixie_dma_source.sv
// pixie_dma_source: CPU-side machine-cycle sequencer for the Pixie display path.
// It runs 8-tick machine cycles. A DMA request gets an S2 fetch through R0, and
// an interrupt request gets an S3 cycle that reloads R0 from base_addr. It also
// emits the display on/off strobes during idle (S1) cycles.
module pixie_dma_source #(
  parameter int CYCLE_TICKS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [15:0] base_addr,
  input  logic        disp_start,
  input  logic        disp_stop,
  input  logic        dma_req,
  input  logic        int_req,
  input  logic        efx,
  input  logic [7:0]  mem_data,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic [1:0]  sc,
  output logic [7:0]  data,
  output logic        disp_on,
  output logic        disp_off,
  output logic        ef1,
  output logic [10:0] dma_count
);

  localparam logic [2:0]  LAST_TICK  = 3'(CYCLE_TICKS - 1);
  localparam logic [2:0]  LATCH_TICK = 3'd3;
  localparam logic [2:0]  STROBE_TICK = 3'd4;
  localparam logic [10:0] COUNT_MAX  = 11'h7FF;

  // The state encoding doubles as the sc bus code.
  typedef enum logic [1:0] {
    SC_EXEC = 2'b01,
    SC_DMA  = 2'b10,
    SC_INT  = 2'b11
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  tick;
  logic [15:0] r0;
  logic        ie;
  logic        on_pend;
  logic        off_pend;
  logic        boundary;

  assign boundary = clk_enable && (tick == LAST_TICK);

  // State register. A new machine-cycle type is only taken at a cycle boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SC_EXEC;
    end else begin
      state <= state_next;
    end
  end

  // Next-cycle decision and bus outputs. DMA has priority over the interrupt.
  // No second S3 is started straight out of an S3.
  always_comb begin
    state_next = state;
    sc         = state;
    mem_addr   = r0;
    mem_rd     = 1'b0;
    disp_on    = 1'b0;
    disp_off   = 1'b0;
    if (boundary) begin
      if (dma_req) begin
        state_next = SC_DMA;
      end else if (int_req && ie && (state != SC_INT)) begin
        state_next = SC_INT;
      end else begin
        state_next = SC_EXEC;
      end
    end
    if ((state == SC_DMA) && (tick != 3'd0) && (tick != LAST_TICK)) begin
      mem_rd = 1'b1;
    end
    if ((state == SC_EXEC) && (tick == STROBE_TICK)) begin
      disp_on  = on_pend;
      disp_off = off_pend && !on_pend;
    end
  end

  // Tick counter within the machine cycle. It wraps at the cycle boundary.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= 3'd0;
    end else if (clk_enable) begin
      tick <= (tick == LAST_TICK) ? 3'd0 : tick + 3'd1;
    end
  end

  // R0 pointer, DMA byte count, interrupt enable and the latched display byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r0        <= 16'h0000;
      ie        <= 1'b1;
      dma_count <= 11'd0;
      data      <= 8'h00;
    end else if (clk_enable) begin
      if ((state == SC_DMA) && (tick == LATCH_TICK)) begin
        data <= mem_data;
      end
      if (tick == LAST_TICK) begin
        case (state)
          SC_DMA: begin
            r0 <= r0 + 16'd1;
            if (dma_count != COUNT_MAX) begin
              dma_count <= dma_count + 11'd1;
            end
          end
          SC_INT: begin
            r0        <= base_addr;
            dma_count <= 11'd0;
          end
          default: begin
          end
        endcase
        if (!int_req) begin
          ie <= 1'b1;
        end else if (state == SC_INT) begin
          ie <= 1'b0;
        end
      end
    end
  end

  // Display strobe requests are remembered on any clock.
  // Each pending flag clears once its strobe has been shown for the whole of tick 4.
  always_ff @(posedge clk) begin
    if (reset) begin
      on_pend  <= 1'b0;
      off_pend <= 1'b0;
    end else begin
      if (disp_start) begin
        on_pend <= 1'b1;
      end else if (clk_enable && disp_on) begin
        on_pend <= 1'b0;
      end
      if (disp_stop) begin
        off_pend <= 1'b1;
      end else if (clk_enable && disp_off) begin
        off_pend <= 1'b0;
      end
    end
  end

  // EF flag synchroniser, qualified by the CPU clock enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      ef1 <= 1'b0;
    end else if (clk_enable) begin
      ef1 <= efx;
    end
  end

endmodule
